// File: rtl/uart_tx_fifo_if.sv
// Port bundle between the UART TX word buffer and its neighbours: the bus write path,
// the serial transmitter, and CSR status readback.
interface uart_tx_fifo_if #(
    parameter int CNT_W = 5
);
    // Byte handshake: a byte transfers on a rising edge where tx_valid && tx_ready are both high.
    // Once tx_valid is high, tx_valid and tx_byte hold until that transfer, unless reset or flush.
    logic             W_en;
    logic [31:0]      Data_in;
    logic             csr_flush;
    logic             tx_ready;
    logic             tx_valid;
    logic [7:0]       tx_byte;
    logic             Full;
    logic             Empty;
    logic             fifo_threshold;
    logic             tx_busy;
    logic             overflow_err;
    logic [CNT_W-1:0] count;
    logic             dbg_state;

    modport master (
        output W_en, Data_in, csr_flush, tx_ready,
        input  tx_valid, tx_byte, Full, Empty, fifo_threshold, tx_busy, overflow_err, count,
               dbg_state
    );

    modport slave (
        input  W_en, Data_in, csr_flush, tx_ready,
        output tx_valid, tx_byte, Full, Empty, fifo_threshold, tx_busy, overflow_err, count,
               dbg_state
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: DEPTH x 32-bit word FIFO feeding a shift stage.
// The shift stage emits each word as four bytes, LSB first, over a valid/ready handshake.
module uart_tx_fifo #(
    parameter int DEPTH     = 16,
    parameter int THRESHOLD = 3
) (
    input logic           clk,
    input logic           reset,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   shreg_q;
    logic [1:0]    byte_idx_q;
    logic          ovf_q;

    logic clear, full, have_word, push, pop, advance, last_byte;

    // Flush behaves exactly like reset and wins over any push or handshake.
    assign clear     = reset | bus.csr_flush;
    assign full      = (count_q == CW'(DEPTH));
    assign have_word = (count_q != '0);
    assign push      = bus.W_en && !full;
    assign advance   = (state_q == S_SHIFT) && bus.tx_ready;
    assign last_byte = (byte_idx_q == 2'd3);
    // Reloading on the byte-3 handshake keeps the byte stream gap-free across words.
    assign pop       = have_word && ((state_q == S_IDLE) || (advance && last_byte));

    always_ff @(posedge clk) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (have_word) state_d = S_SHIFT;
            S_SHIFT: if (advance && last_byte && !have_word) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_valid  = 1'b0;
        bus.tx_busy   = 1'b0;
        bus.dbg_state = state_q;
        bus.tx_byte   = shreg_q[7:0];
        if (state_q == S_SHIFT) begin
            bus.tx_valid = 1'b1;
            bus.tx_busy  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wptr_q] <= bus.Data_in;
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (bus.W_en && full) ovf_q <= 1'b1;
            if (pop) begin
                shreg_q    <= mem[rptr_q];
                byte_idx_q <= 2'd0;
            end else if (advance && !last_byte) begin
                shreg_q    <= {8'h00, shreg_q[31:8]};
                byte_idx_q <= byte_idx_q + 2'd1;
            end
        end
    end

    assign bus.Full           = full;
    assign bus.Empty          = !have_word;
    assign bus.fifo_threshold = (count_q <= CW'(THRESHOLD));
    assign bus.count          = count_q;
    assign bus.overflow_err   = ovf_q;
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer of the UART, sitting between the CSR/bus write path and the serial transmitter. It stores up to 16 32-bit words pushed by software and unpacks each word into four bytes, LSB first. The bytes are handed to the transmitter over a valid/ready byte handshake. It reports full, empty, almost-empty (refill) and overflow status, and can be flushed by a CSR bit.

## Interface
Parameters:
- DEPTH, 16: word entries; power of two.
- THRESHOLD, 3: fifo_threshold asserts when count <= THRESHOLD.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- W_en  in  1  push Data_in this cycle.
- Data_in  in  32  word to transmit; byte 0 = [7:0] goes out first.
- csr_flush  in  1  synchronous flush; level-sensitive, acts every cycle it is high.
- tx_ready  in  1  transmitter accepts tx_byte this cycle.
- tx_valid  out  1  tx_byte holds a valid byte.
- tx_byte  out  8  byte to the transmitter.
- Full  out  1  count == DEPTH.
- Empty  out  1  count == 0 (word storage only).
- fifo_threshold  out  1  count <= THRESHOLD; refill request.
- tx_busy  out  1  output stage holds a word (state SHIFT).
- overflow_err  out  1  sticky; a push was attempted while Full.
- count  out  5  stored words, 0..16; excludes the word in the output stage.

## Operation
- Storage: DEPTH x 32 memory, 4-bit wptr/rptr, natural wrap 15 -> 0. All 16 entries are usable; Full only at count 16.
- Push: W_en && !Full writes memory[wptr], then wptr+1. A push while Full is dropped, pointers unchanged, and overflow_err sets. Full is evaluated on pre-edge count, so a push while Full is dropped even if a pop happens in the same cycle.
- Output stage: 32-bit shift register shreg, 2-bit byte_idx, FSM with two states.
  - IDLE: tx_valid=0. If count>0, pop memory[rptr] into shreg, byte_idx=0, rptr+1, go to SHIFT.
  - SHIFT: tx_valid=1, tx_byte=shreg[7:0].
    - tx_ready with byte_idx<3: shreg >>= 8, byte_idx+1.
    - tx_ready with byte_idx==3 and count>0 (pre-edge): pop the next word directly into shreg and stay in SHIFT. No bubble cycle.
    - tx_ready with byte_idx==3 and count==0: go to IDLE.
    - tx_ready low: hold all state. tx_byte stays stable while tx_valid && !tx_ready.
- Count: +1 on accepted push, -1 on pop; simultaneous push and pop leaves it unchanged.
- Flush (csr_flush=1) and reset (reset=1) have identical effect, taking priority over W_en and tx_ready:
  - pointers, count, shreg, byte_idx cleared; FSM to IDLE; overflow_err cleared.
  - memory contents need not be cleared.
  - reset also clears if asserted mid-word; the remaining bytes are discarded.
- Status outputs Full, Empty, fifo_threshold and count are combinational from registered count.

## Timing
- Reset values: tx_valid=0, tx_byte=0x00, tx_busy=0, Full=0, Empty=1, fifo_threshold=1, overflow_err=0, count=0.
- First-byte latency: push sampled at edge E0 into an empty, idle block gives count=1 after E0. Pop at E1 gives tx_valid=1 with byte 0 after E1 and count back to 0.
- Throughput: with tx_ready held high, one byte per cycle continuously across word boundaries, as long as count>0 at each byte-3 handshake.
- tx_valid never drops without a completed handshake, except on reset or flush, where it drops after the next edge.
- overflow_err sets at the edge that samples the dropped push and stays high until reset or flush.
- fifo_threshold and Empty update the cycle after the causing edge; there is no extra register stage.

## Test plan
- Reset, then push 0x44332211 with tx_ready=1 -> tx_valid rises 1 cycle after the push edge. Bytes 0x11, 0x22, 0x33, 0x44 appear on consecutive cycles, then tx_valid=0. Empty=1 throughout after the pop.
- tx_ready=0, push 17 words 0..16 -> count reaches 15 (one word in shreg) after 16 pushes. Full=1 after the 17th push (count 16 only if the stage is already loaded; check count==16, Full=1). A further push sets overflow_err=1 and count is unchanged.
- Push 3 words, then toggle tx_ready 1/0 every cycle -> tx_byte is stable during each stall. 12 bytes arrive in order with no duplicates or gaps. The word boundary has no bubble when tx_ready=1.
- Fill to count 8 and drain -> fifo_threshold goes 0 -> 1 exactly when count becomes 3. Empty=1 when count is 0 while tx_busy=1 is still sending the last word.
- Mid-word (byte_idx=2), assert csr_flush for 1 cycle with W_en=1 -> next cycle tx_valid=0, count=0, overflow_err=0, the push is ignored. A subsequent push restarts at byte 0.
- With count=16 and a byte-3 handshake, a same-cycle push is dropped and overflow_err=1. Then push and pop in the same cycle at count 5 -> count stays 5; run wptr/rptr wrap past 15 with data intact.
